// File: rtl/mp_add_seq_if.sv
//------------------------------------------------------------------------------
// Module      : mp_add_seq_if
// Description : Request, operand-stream and result-stream signals of the
//               multi-word sequential adder/subtractor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mp_add_seq_if #(
    parameter int BITS = 32,
    parameter int LENW = 8
);
    logic            start;
    logic            sub;
    logic [LENW-1:0] len;
    logic            op_valid;
    logic            op_ready;
    logic [BITS-1:0] a_in;
    logic [BITS-1:0] b_in;
    logic            res_valid;
    logic            res_ready;
    logic [BITS-1:0] s_out;
    logic            res_last;
    logic            c_out;
    logic            busy;
    logic            done;

    // Requester / operand source / result consumer side
    modport master (
        output start, sub, len, op_valid, a_in, b_in, res_ready,
        input  op_ready, res_valid, s_out, res_last, c_out, busy, done
    );

    // Arithmetic block side
    modport slave (
        input  start, sub, len, op_valid, a_in, b_in, res_ready,
        output op_ready, res_valid, s_out, res_last, c_out, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/mp_add_seq.sv
//------------------------------------------------------------------------------
// Module      : mp_add_seq
// Description : Multi-word add/subtract. Operand words arrive least
//               significant first and stream through a single shared
//               ripple-carry adder; the carry is kept in a register between
//               words. One registered result word is produced per operand.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mp_add_seq #(
    parameter int BITS = 32,
    parameter int LENW = 8
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    mp_add_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_sub;
    logic [LENW-1:0] r_cnt;
    logic            r_carry;
    logic [BITS-1:0] r_s_out;
    logic            r_res_valid;
    logic            r_res_last;
    logic            r_c_out;
    logic            r_done;

    logic [BITS-1:0] w_b_opd;
    logic [BITS-1:0] w_sum;
    logic [BITS:0]   w_c;
    logic            w_op_ready;
    logic            w_op_hs;
    logic            w_res_hs;

    // Subtraction is A + ~B + 1: the +1 enters as the word-0 carry, which
    // the carry register was loaded with when the operation started.
    assign w_b_opd = r_sub ? ~bus.b_in : bus.b_in;
    assign w_c[0]  = r_carry;

    // Shared ripple-carry adder, one full-adder cell per bit.
    for (genvar gi = 0; gi < BITS; gi++) begin : g_rca
        assign w_sum[gi]  = bus.a_in[gi] ^ w_b_opd[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (bus.a_in[gi] & w_b_opd[gi]) |
                            (bus.a_in[gi] & w_c[gi])     |
                            (w_b_opd[gi]  & w_c[gi]);
    end

    // An operand may be taken only when the result slot is free or
    // being emptied this cycle, so a stalled result is never overwritten.
    assign w_op_ready = (r_state == RUN) && (!r_res_valid || bus.res_ready);
    assign w_op_hs    = bus.op_valid && w_op_ready;
    assign w_res_hs   = r_res_valid && bus.res_ready;

    // Control FSM together with the result and carry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sub       <= 1'b0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_s_out     <= '0;
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            r_c_out     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start && (bus.len != '0)) begin
                        r_sub   <= bus.sub;
                        r_cnt   <= bus.len;
                        r_carry <= bus.sub;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_op_hs) begin
                        r_s_out     <= w_sum;
                        r_carry     <= w_c[BITS];
                        r_res_valid <= 1'b1;
                        r_cnt       <= r_cnt - LENW'(1);
                        if (r_cnt == LENW'(1)) begin
                            r_res_last <= 1'b1;
                            r_c_out    <= w_c[BITS];
                            r_state    <= DRAIN;
                        end else begin
                            r_res_last <= 1'b0;
                            r_c_out    <= 1'b0;
                        end
                    end else if (w_res_hs) begin
                        r_res_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    // The only word left in flight is the final one.
                    if (w_res_hs) begin
                        r_res_valid <= 1'b0;
                        r_res_last  <= 1'b0;
                        r_c_out     <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.op_ready  = w_op_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.s_out     = r_s_out;
    assign bus.res_last  = r_res_last;
    assign bus.c_out     = r_c_out;
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mp_add_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_mp_add_seq
// Description : Directed, table-driven bench for mp_add_seq with BITS = 8.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mp_add_seq;

    localparam int BITS = 8;
    localparam int LENW = 8;

    typedef struct packed {
        logic        sub;
        logic [7:0]  len;
        logic [31:0] a;     // word i in bits [8*i +: 8]
        logic [31:0] b;
        logic [31:0] s;     // expected result words
        logic        cout;  // expected final carry
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    vec_t vecs [8];

    mp_add_seq_if #(.BITS(BITS), .LENW(LENW)) bus ();

    mp_add_seq #(.BITS(BITS), .LENW(LENW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " op_ready"},  32'(bus.op_ready),  32'd0);
        chk({tag, " res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, " res_last"},  32'(bus.res_last),  32'd0);
        chk({tag, " c_out"},     32'(bus.c_out),     32'd0);
        chk({tag, " s_out"},     32'(bus.s_out),     32'd0);
        chk({tag, " busy"},      32'(bus.busy),      32'd0);
        chk({tag, " done"},      32'(bus.done),      32'd0);
    endtask

    // Runs one operation. Called and returns at 1 time unit after a rising edge.
    // stall: hold res_ready low for 3 cycles once the first result is due.
    // spurious: keep start high with a bogus length while operands stream.
    task automatic run_op(input vec_t v, input bit stall, input bit spurious);
        int di, ri, cyc, stall_left;
        bit hs, trig, prev_hs, prev_rv, prev_rr;
        int len;
        len = int'(v.len);
        bus.start = 1'b1;
        bus.sub   = v.sub;
        bus.len   = v.len;
        @(posedge clk); #1;
        bus.start = 1'b0;
        di = 0; ri = 0; cyc = 0; stall_left = 0;
        trig = 0; prev_hs = 0; prev_rv = 0; prev_rr = 0;
        while (ri < len && cyc < 200) begin
            // drive
            if (spurious && di < len) begin
                bus.start = 1'b1;
                bus.len   = 8'd5;
            end else begin
                bus.start = 1'b0;
            end
            bus.op_valid = (di < len);
            bus.a_in     = v.a[8*(di%4) +: 8];
            bus.b_in     = v.b[8*(di%4) +: 8];
            if (stall && !trig && di == 1) begin
                trig = 1;
                stall_left = 3;
            end
            bus.res_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            // sample
            @(negedge clk);
            chk("busy in op", 32'(bus.busy), 32'd1);
            chk("res_valid timing", 32'(bus.res_valid), 32'(prev_hs | (prev_rv & !prev_rr)));
            if (bus.res_valid && !bus.res_ready) begin
                chk("op_ready stalled", 32'(bus.op_ready), 32'd0);
                chk("s_out held", 32'(bus.s_out), 32'(v.s[8*(ri%4) +: 8]));
            end
            if (bus.res_valid && bus.res_ready) begin
                chk($sformatf("s_out word%0d", ri), 32'(bus.s_out), 32'(v.s[8*(ri%4) +: 8]));
                chk($sformatf("res_last word%0d", ri), 32'(bus.res_last), 32'(ri == len - 1));
                if (ri == len - 1) chk("c_out", 32'(bus.c_out), 32'(v.cout));
                ri++;
            end
            hs      = bus.op_valid && bus.op_ready;
            prev_hs = hs;
            prev_rv = bus.res_valid;
            prev_rr = bus.res_ready;
            @(posedge clk); #1;
            if (hs) di++;
            cyc++;
        end
        if (ri < len) chk("result count (timeout)", 32'(ri), 32'(len));
        bus.start    = 1'b0;
        bus.op_valid = 1'b0;
        chk("done pulse", 32'(bus.done), 32'd1);
        chk("busy after op", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        chk("done cleared", 32'(bus.done), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        //            sub  len    A             B             S             cout
        vecs[0] = '{1'b0, 8'd2, 32'h0000_01FF, 32'h0000_0001, 32'h0000_0200, 1'b0};
        vecs[1] = '{1'b1, 8'd1, 32'h0000_0005, 32'h0000_0007, 32'h0000_00FE, 1'b0};
        vecs[2] = '{1'b1, 8'd1, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1};
        vecs[3] = '{1'b0, 8'd3, 32'h00FF_FFFF, 32'h00FF_FFFF, 32'h00FF_FFFE, 1'b1};
        vecs[4] = '{1'b1, 8'd2, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b1};
        vecs[5] = '{1'b1, 8'd2, 32'h0000_0001, 32'h0000_0002, 32'h0000_FFFF, 1'b0};
        vecs[6] = '{1'b0, 8'd4, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};
        vecs[7] = '{1'b0, 8'd1, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.sub       = 1'b0;
        bus.len       = '0;
        bus.op_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.res_ready = 1'b1;
        #2;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain streaming vectors with the consumer always ready.
        for (int i = 0; i < 8; i++) run_op(vecs[i], 1'b0, 1'b0);

        // 0xFF+0xFF chain with the consumer stalling after the first result.
        run_op(vecs[3], 1'b1, 1'b0);

        // start with len == 0 is ignored.
        bus.start = 1'b1;
        bus.len   = 8'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("len0 busy", 32'(bus.busy), 32'd0);
        chk("len0 op_ready", 32'(bus.op_ready), 32'd0);
        @(negedge clk);
        chk("len0 res_valid", 32'(bus.res_valid), 32'd0);
        @(posedge clk); #1;

        // start held during RUN must not reload the word count.
        run_op(vecs[4], 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no extra result", 32'(bus.res_valid), 32'd0);
            chk("idle busy", 32'(bus.busy), 32'd0);
        end
        @(posedge clk); #1;

        // Reset in the middle of a 4-word add.
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.len   = 8'd4;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.op_valid = 1'b1;
        bus.a_in     = 8'h11;
        bus.b_in     = 8'h22;
        @(posedge clk); #1;
        bus.a_in = 8'h33;
        bus.b_in = 8'h44;
        @(negedge clk);
        chk("pre-reset s_out", 32'(bus.s_out), 32'h33);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid-op reset");
        bus.op_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post-reset res_valid", 32'(bus.res_valid), 32'd0);
            chk("post-reset busy", 32'(bus.busy), 32'd0);
        end
        @(posedge clk); #1;
        run_op(vecs[7], 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
